// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM between fetch and memory stages with wait states and freeze.
// Optional ARB_PERF_CNT_EN adds per-requester saturating wait-cycle counters.
module sram_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       if_wait_cnt,
    output logic [15:0]       mem_wait_cnt,
`endif
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic gnt_mem, we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    always_comb begin
        state_nxt = (state == IDLE)   ? ((mem_req | if_req) ? ACCESS : IDLE) :
                    (state == ACCESS) ? ((cnt == 4'd0) ? DONE : ACCESS) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_mem   <= 1'b0;
            we_l      <= 1'b0;
            addr_l    <= '0;
            wdata_l   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            // mem wins ties: it carries the older instruction
            if (state == IDLE && (mem_req | if_req)) begin
                gnt_mem <= mem_req;
                we_l    <= mem_req & mem_we;
                addr_l  <= mem_req ? mem_addr : if_addr;
                cnt     <= 4'(WAIT_CYCLES - 1);
                if (mem_req) wdata_l <= mem_wdata;
            end
            if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd0 && !we_l && gnt_mem) mem_rdata <= sram_rdata;
                if (cnt == 4'd0 && !we_l && !gnt_mem) if_rdata <= sram_rdata;
            end
        end
    end
    assign if_ready   = (state == DONE) & ~gnt_mem;
    assign mem_ready  = (state == DONE) & gnt_mem;
    assign freeze     = (if_req & ~if_ready) | (mem_req & ~mem_ready);
    assign sram_ce_n  = ~(state == ACCESS);
    assign sram_oe_n  = ~((state == ACCESS) & ~we_l);
    assign sram_we_n  = ~((state == ACCESS) & we_l);
    assign sram_addr  = addr_l;
    assign sram_wdata = wdata_l;
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_wait_cnt  <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (if_req && !if_ready && if_wait_cnt != 16'hFFFF) if_wait_cnt <= if_wait_cnt + 16'd1;
            if (mem_req && !mem_ready && mem_wait_cnt != 16'hFFFF) mem_wait_cnt <= mem_wait_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter (WAIT_CYCLES=3).
module tb_sram_port_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, sram_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic if_ready, mem_ready, freeze, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] if_wait_cnt, mem_wait_cnt;
`endif
    int n_cmp = 0, n_err = 0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
`ifdef ARB_PERF_CNT_EN
        .if_wait_cnt(if_wait_cnt), .mem_wait_cnt(mem_wait_cnt),
`endif
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("rst_addr", sram_addr, 0);
        rst = 1'b1;
        tick();

        // IF read
        if_addr = 32'h40; if_req = 1'b1; sram_rdata = 32'hE3A00001;
        #1;
        chk("if_c0_freeze", freeze, 1);
        chk("if_c0_oe", sram_oe_n, 1);
        tick();
        chk("if_c1_oe", sram_oe_n, 0);
        chk("if_c1_ce", sram_ce_n, 0);
        chk("if_c1_addr", sram_addr, 32'h40);
        chk("if_c1_ready", if_ready, 0);
        tick();
        chk("if_c2_oe", sram_oe_n, 0);
        tick();
        chk("if_c3_oe", sram_oe_n, 0);
        chk("if_c3_freeze", freeze, 1);
        chk("if_c3_ready", if_ready, 0);
        tick();
        chk("if_c4_ready", if_ready, 1);
        chk("if_c4_rdata", if_rdata, 32'hE3A00001);
        chk("if_c4_oe", sram_oe_n, 1);
        chk("if_c4_freeze", freeze, 0);
        if_req = 1'b0;
        tick();
        chk("if_c5_ready", if_ready, 0);
        chk("if_c5_hold", if_rdata, 32'hE3A00001);

        // clean reset so wait counters start from zero
        rst = 1'b0; tick(); rst = 1'b1; tick();

        // simultaneous requests: mem first
        if_addr = 32'h44; if_req = 1'b1;
        mem_addr = 32'h100; mem_we = 1'b0; mem_req = 1'b1; sram_rdata = 32'h11112222;
        tick(); tick(); tick();
        chk("sim_c3_freeze", freeze, 1);
        tick();
        chk("sim_c4_mem_ready", mem_ready, 1);
        chk("sim_c4_if_ready", if_ready, 0);
        chk("sim_c4_addr", sram_addr, 32'h100);
        chk("sim_c4_mem_rdata", mem_rdata, 32'h11112222);
        chk("sim_c4_freeze", freeze, 1);
        mem_req = 1'b0; sram_rdata = 32'h33334444;
        tick();
        chk("sim_c5_freeze", freeze, 1);
        chk("sim_c5_ce", sram_ce_n, 1);
        tick();
        chk("sim_c6_addr", sram_addr, 32'h44);
        chk("sim_c6_oe", sram_oe_n, 0);
        tick(); tick();
        chk("sim_c8_freeze", freeze, 1);
        chk("sim_c8_if_ready", if_ready, 0);
        tick();
        chk("sim_c9_if_ready", if_ready, 1);
        chk("sim_c9_mem_ready", mem_ready, 0);
        chk("sim_c9_if_rdata", if_rdata, 32'h33334444);
        chk("sim_c9_mem_rdata", mem_rdata, 32'h11112222);
        chk("sim_c9_freeze", freeze, 0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_mem_wait", mem_wait_cnt, 4);
        chk("perf_if_wait", if_wait_cnt, 9);
`endif
        if_req = 1'b0;
        tick();

        // write; data changed mid-access must not reach the SRAM
        mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_req = 1'b1;
        sram_rdata = 32'hBADBAD00;
        tick();
        chk("wr_c1_we", sram_we_n, 0);
        chk("wr_c1_oe", sram_oe_n, 1);
        chk("wr_c1_wdata", sram_wdata, 32'hDEADBEEF);
        chk("wr_c1_addr", sram_addr, 32'h200);
        mem_wdata = 32'h0; mem_addr = 32'h0;
        tick();
        chk("wr_c2_we", sram_we_n, 0);
        tick();
        chk("wr_c3_we", sram_we_n, 0);
        chk("wr_c3_wdata", sram_wdata, 32'hDEADBEEF);
        chk("wr_c3_addr", sram_addr, 32'h200);
        tick();
        chk("wr_c4_ready", mem_ready, 1);
        chk("wr_c4_we", sram_we_n, 1);
        chk("wr_c4_rdata", mem_rdata, 32'h11112222);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();

        // reset mid-access, then restart
        if_addr = 32'h80; if_req = 1'b1; sram_rdata = 32'h55667788;
        tick(); tick();
        chk("ra_c2_oe", sram_oe_n, 0);
        rst = 1'b0;
        #1;
        chk("ra_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("ra_ready", if_ready, 0);
        chk("ra_rdata", if_rdata, 0);
        tick();
        chk("ra_hold_ready", if_ready, 0);
        rst = 1'b1;
        tick(); tick(); tick();
        chk("ra_c3_ready", if_ready, 0);
        chk("ra_c3_addr", sram_addr, 32'h80);
        tick();
        chk("ra_c4_ready", if_ready, 1);
        chk("ra_c4_rdata", if_rdata, 32'h55667788);
        if_req = 1'b0;
        tick();
        chk("ra_c5_ready", if_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported instruction/data SRAM between the fetch stage and the memory stage of the 5-stage ARM pipeline.
- Sequences each SRAM access with a programmable wait-state count.
- Returns data and a one-cycle ready pulse to the requester.
- Generates the pipeline-wide freeze signal while any requester is stalled.

Parameters:
- ADDR_W, 32, width of requester and SRAM address buses.
- DATA_W, 32, width of data buses.
- WAIT_CYCLES, 3, SRAM access time in clk cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch read request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready=1, then held.
- if_ready  out  1  one-cycle completion pulse to fetch.
- mem_req  in  1  memory-stage request; level, held until mem_ready.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid when mem_ready=1, then held.
- mem_ready  out  1  one-cycle completion pulse to the memory stage.
- freeze  out  1  pipeline stall: (if_req & ~if_ready) | (mem_req & ~mem_ready).
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - FSM = IDLE; if_ready=0, mem_ready=0.
  - if_rdata=0, mem_rdata=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - sram_addr=0, sram_wdata=0.
  - freeze follows its combinational equation, so it equals the request inputs during reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_req=1, grant MEM: latch mem_addr, mem_wdata, mem_we; load wait counter with WAIT_CYCLES-1; go to ACCESS.
  - Else if if_req=1, grant IF: latch if_addr, we=0; same counter load; go to ACCESS.
  - Else stay in IDLE.
  - Fixed priority: MEM over IF, because the memory stage holds the older instruction.
- ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0.
  - Write: sram_we_n=0, and sram_wdata = latched data.
  - sram_addr holds the latched address for the whole state.
  - Counter decrements each cycle; when it reaches 0, capture sram_rdata into the granted requester's rdata register (reads only) and go to DONE.
- DONE:
  - SRAM strobes deasserted (all 1).
  - Pulse the granted ready output high for exactly one cycle, then go to IDLE.
  - Writes leave mem_rdata unchanged.
- Latency: request sampled in IDLE at cycle 0 → ready high at cycle WAIT_CYCLES+1.
  - Back-to-back accesses take WAIT_CYCLES+2 cycles each (the IDLE cycle is included).
- Simultaneous requests: MEM is served first. IF is granted in the next IDLE cycle if if_req is still high.
- Requester drops req mid-access: the access still completes and the ready pulse is still issued; the requester ignores it.
- Requester keeps req high in the cycle after ready: treated as a new request.
- Requesters must change addr/data only after ready. The arbiter uses latched copies, so mid-access changes have no effect.
- Reset asserted mid-access:
  - Strobes release immediately and the FSM returns to IDLE.
  - No ready pulse is issued and no rdata is updated.
- freeze is purely combinational; it is never registered.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs if_wait_cnt and mem_wait_cnt (16 bits each).
  - Each counts cycles where that requester's req=1 and ready=0.
  - Saturates at 0xFFFF; reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with if_req=0 and mem_req=0 → if_ready=0, mem_ready=0, freeze=0, sram_ce_n=sram_oe_n=sram_we_n=1, if_rdata=mem_rdata=0.
- IF read, WAIT_CYCLES=3, if_addr=0x40, sram_rdata=0xE3A00001 → sram_oe_n=0 for cycles 1-3, if_ready pulse at cycle 4, if_rdata=0xE3A00001, freeze=1 in cycles 0-3.
- Simultaneous if_req (0x44) and mem_req read (0x100) at cycle 0 → mem_ready at cycle 4 with sram_addr=0x100; if_ready at cycle 9 with sram_addr=0x44; freeze=1 through cycle 8.
- Write mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF → sram_we_n=0 for cycles 1-3 with sram_wdata=0xDEADBEEF; mem_ready at cycle 4; mem_rdata unchanged.
- rst=0 pulsed in cycle 2 of an IF access → strobes go to 1 immediately, no if_ready pulse; after release with if_req still high, the access restarts and completes 4 cycles later.
- With ARB_PERF_CNT_EN, the scenario-3 stimulus → mem_wait_cnt=4, if_wait_cnt=9.
